apb_clk_div_ctrl: RTL and testbench

- Parametrised APB configuration front-end for N clock-divider channels.
- Fully APB3-compliant slave: setup phase, then access phase, with wait states. Reads return real values. Unmapped accesses answer with pslverr.
- Drives a valid/ack handshake into each channel's clock divider. Keeps a readable shadow of each channel's divider value and gate bit.
- Sits in the SoC clock/reset generator between the peripheral APB bus and the divider instances; replaces the fixed three-channel decoder.

---
 rtl/apb_clk_div_ctrl_pkg.sv | 15 +
 rtl/apb_clk_div_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_apb_clk_div_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_clk_div_ctrl_pkg.sv
// Shared state encoding and register-map constants for apb_clk_div_ctrl.
package apb_clk_div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned BUSY_LSB  = 0;
  localparam int unsigned ERR_LSB   = 16;
  localparam int unsigned GATE_BIT  = 31;
  localparam int unsigned CH_STRIDE = 8;

endpackage

// File: rtl/apb_clk_div_ctrl.sv
// APB3 configuration front-end for N_CH clock dividers with a per-channel valid/ack update handshake.
// Optional ack timeout is compiled in when APB_CLK_DIV_CTRL_TIMEOUT_EN is defined.
module apb_clk_div_ctrl
  import apb_clk_div_ctrl_pkg::*;
#(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned DIV_INIT       = 0,
  parameter bit          GATE_INIT      = 1'b1,
  parameter logic [11:0] BASE_OFF       = 12'hF00,
  parameter logic [11:0] STAT_OFF       = 12'hFF0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [11:0]               paddr_i,
  input  logic [31:0]               pwdata_i,
  input  logic                      pwrite_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  output logic [31:0]               prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  output logic [DIV_WIDTH-1:0]      div_data_o,
  output logic [N_CH-1:0]           div_valid_o,
  input  logic [N_CH-1:0]           div_ack_i,
  output logic [N_CH-1:0]           gate_en_o,
  output logic [N_CH*DIV_WIDTH-1:0] div_value_o
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d, ch_idx;
  logic                 gate_pend_q, gate_pend_d;
  logic                 abort_q, abort_d;
  logic [N_CH-1:0]      sticky_q, sticky_d, valid_d, busy;
  logic [DIV_WIDTH-1:0] data_d;
  logic [31:0]          prdata_d, ch_rdata, stat_rdata;
  logic                 pready_d, pslverr_d, upd, timeout;
  logic                 access, aligned, ch_hit, stat_hit;
  logic [DIV_WIDTH-1:0] shadow_q [N_CH];
  logic                 gate_q   [N_CH];
  logic                 unused;

  assign unused   = ^pwdata_i;
  assign access   = psel_i & penable_i;
  assign aligned  = (paddr_i[1:0] == 2'b00);
  assign stat_hit = (paddr_i == STAT_OFF);
  assign busy     = (state_q == REQ) ? (N_CH'(1) << ch_q) : '0;

  // Exact-match channel address decode
  always_comb begin
    ch_hit = 1'b0;
    ch_idx = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (paddr_i == 12'(BASE_OFF + CH_STRIDE * k)) begin
        ch_hit = 1'b1;
        ch_idx = CH_W'(k);
      end
    end
  end

  always_comb begin
    ch_rdata                     = '0;
    ch_rdata[DIV_WIDTH-1:0]      = shadow_q[ch_idx];
    ch_rdata[GATE_BIT]           = gate_q[ch_idx];
    stat_rdata                   = '0;
    stat_rdata[BUSY_LSB +: N_CH] = busy;
    stat_rdata[ERR_LSB +: N_CH]  = sticky_q;
  end

`ifdef APB_CLK_DIV_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Counts cycles spent waiting for ack; restarts on every entry to REQ
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             to_cnt_q <= '0;
    else if (state_q != REQ) to_cnt_q <= '0;
    else                     to_cnt_q <= to_cnt_q + TO_W'(1);
  end

  assign timeout = (state_q == REQ) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Next-state and registered-output logic; pready_o high blocks re-decoding the completing access
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    gate_pend_d = gate_pend_q;
    abort_d     = abort_q;
    sticky_d    = sticky_q;
    valid_d     = div_valid_o;
    data_d      = div_data_o;
    prdata_d    = '0;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    upd         = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !pready_o) begin
          if (!aligned || !(ch_hit || stat_hit)) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (stat_hit) begin
            pready_d = 1'b1;
            if (pwrite_i) sticky_d = sticky_q & ~pwdata_i[ERR_LSB +: N_CH];
            else          prdata_d = stat_rdata;
          end else if (pwrite_i) begin
            data_d      = pwdata_i[DIV_WIDTH-1:0];
            gate_pend_d = pwdata_i[GATE_BIT];
            ch_d        = ch_idx;
            valid_d     = N_CH'(1) << ch_idx;
            abort_d     = 1'b0;
            state_d     = REQ;
          end else begin
            pready_d = 1'b1;
            prdata_d = ch_rdata;
          end
        end
      end
      REQ: begin
        if (!access) abort_d = 1'b1;
        if (div_ack_i[ch_q]) begin
          valid_d  = '0;
          upd      = 1'b1;
          pready_d = access & ~abort_q;
          state_d  = RESP;
        end else if (timeout) begin
          valid_d        = '0;
          sticky_d[ch_q] = 1'b1;
          pready_d       = access & ~abort_q;
          pslverr_d      = access & ~abort_q;
          state_d        = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      gate_pend_q <= 1'b0;
      abort_q     <= 1'b0;
      sticky_q    <= '0;
      prdata_o    <= '0;
      pready_o    <= 1'b0;
      pslverr_o   <= 1'b0;
      div_valid_o <= '0;
      div_data_o  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      gate_pend_q <= gate_pend_d;
      abort_q     <= abort_d;
      sticky_q    <= sticky_d;
      prdata_o    <= prdata_d;
      pready_o    <= pready_d;
      pslverr_o   <= pslverr_d;
      div_valid_o <= valid_d;
      div_data_o  <= data_d;
    end
  end

  // Per-channel shadows: updated only on a completed handshake
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        shadow_q[k] <= DIV_WIDTH'(DIV_INIT);
        gate_q[k]   <= GATE_INIT;
      end else if (upd && (ch_q == CH_W'(k))) begin
        shadow_q[k] <= div_data_o;
        gate_q[k]   <= gate_pend_q;
      end
    end
    assign gate_en_o[k]                           = gate_q[k];
    assign div_value_o[k*DIV_WIDTH +: DIV_WIDTH] = shadow_q[k];
  end

endmodule

// File: tb/tb_apb_clk_div_ctrl.sv
// Randomized self-checking bench for apb_clk_div_ctrl against a transaction-level register model.
module tb_apb_clk_div_ctrl;

  localparam int N_CH  = 3;
  localparam int DW    = 8;
  localparam int TO    = 16;
  localparam int LIMIT = 64;
  localparam logic [11:0] STAT = 12'hFF0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [11:0]       paddr = '0;
  logic [31:0]       pwdata = '0;
  logic              pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
  logic [31:0]       prdata;
  logic              pready, pslverr;
  logic [DW-1:0]     div_data;
  logic [N_CH-1:0]   div_valid, gate_en;
  logic [N_CH-1:0]   div_ack = '0;
  logic [N_CH*DW-1:0] div_value;

  apb_clk_div_ctrl #(
    .N_CH(N_CH), .DIV_WIDTH(DW), .DIV_INIT(0), .GATE_INIT(1'b1),
    .BASE_OFF(12'hF00), .STAT_OFF(STAT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel), .penable_i(penable), .prdata_o(prdata), .pready_o(pready),
    .pslverr_o(pslverr), .div_data_o(div_data), .div_valid_o(div_valid),
    .div_ack_i(div_ack), .gate_en_o(gate_en), .div_value_o(div_value)
  );

  always #5 clk = ~clk;

  int unsigned m_div    [N_CH];
  bit          m_gate   [N_CH];
  bit          m_sticky [N_CH];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          prev_ready = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_div[k] = 0; m_gate[k] = 1'b1; m_sticky[k] = 1'b0;
    end
  endfunction

  function automatic logic [N_CH*DW-1:0] model_value();
    logic [N_CH*DW-1:0] v = '0;
    for (int k = 0; k < N_CH; k++) v[k*DW +: DW] = DW'(m_div[k]);
    return v;
  endfunction

  function automatic logic [N_CH-1:0] model_gate();
    logic [N_CH-1:0] g = '0;
    for (int k = 0; k < N_CH; k++) g[k] = m_gate[k];
    return g;
  endfunction

  function automatic int ch_of(input logic [11:0] a);
    for (int k = 0; k < N_CH; k++) if (a == 12'(12'hF00 + 8 * k)) return k;
    return -1;
  endfunction

  // Expected response of one transaction from the register map rules
  function automatic void predict(input logic [11:0] a, input bit wr, input int d,
                                  output logic [31:0] er, output bit ee, output int el, output bit crd);
    int k = ch_of(a);
    er = '0; ee = 1'b0; el = 1; crd = !wr;
    if (k >= 0) begin
      if (wr) begin
        el = (d < 0) ? TO + 1 : d + 2;
        ee = (d < 0);
      end else begin
        er = (32'(m_gate[k]) << 31) | m_div[k];
      end
    end else if (a == STAT) begin
      if (!wr) for (int j = 0; j < N_CH; j++) er[16 + j] = m_sticky[j];
    end else begin
      ee = 1'b1; crd = 1'b1;
    end
  endfunction

  // One APB transfer; d = cycles the ack lags valid (0 = ack already high, <0 = never ack)
  task automatic apb(input logic [11:0] a, input bit wr, input logic [31:0] wd, input int d,
                     input bit abort, output logic [31:0] rd, output bit err,
                     output int lat, output bit ok);
    int k; int vseen; bit hs; bit hs_pend; bit own; bit exp_v;
    logic [N_CH-1:0] oh;
    k = wr ? ch_of(a) : -1;
    vseen = 0; hs = 1'b0; hs_pend = 1'b0; ok = 1'b0; rd = '0; err = 1'b0; lat = 0; oh = '0;
    if (k >= 0) oh[k] = 1'b1;
    @(negedge clk);
    paddr = a; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    div_ack = '0;
    if (k >= 0 && d == 0) div_ack = oh;
    @(negedge clk);
    penable = 1'b1;
    for (int i = 1; i <= LIMIT; i++) begin
      @(posedge clk);
      if (hs_pend) begin
        hs = 1'b1;
        m_div[k]  = 32'(wd[DW-1:0]);
        m_gate[k] = wd[31];
      end
      hs_pend = 1'b0;
      @(negedge clk);
      lat = i;
      if (k >= 0) begin
        exp_v = !hs && (d >= 0 || i <= TO);
        check("div_valid", div_valid, exp_v ? oh : '0);
        if (exp_v) check("div_data", div_data, wd[DW-1:0]);
        if (div_valid[k]) vseen++;
        own = !hs && d >= 0 && vseen > d;
        div_ack = N_CH'($urandom) & ~oh;
        if (own) div_ack = div_ack | oh;
        hs_pend = own && div_valid[k];
      end else begin
        check("no_valid", div_valid, '0);
        div_ack = N_CH'($urandom);
      end
      if (abort) begin
        check("abort_no_ready", pready, 1'b0);
        if (i == 1) begin psel = 1'b0; penable = 1'b0; end
        if (hs && i >= d + 4) begin ok = 1'b1; break; end
      end else if (pready) begin
        rd = prdata; err = pslverr; ok = 1'b1;
        psel = 1'b0; penable = 1'b0;
        break;
      end
    end
    div_ack = '0; psel = 1'b0; penable = 1'b0;
    if (ok && !abort && k >= 0 && d < 0) m_sticky[k] = 1'b1;
  endtask

  task automatic txn(input logic [11:0] a, input bit wr, input logic [31:0] wd, input int d,
                     output logic [31:0] rd, output bit err, output int lat);
    logic [31:0] er; bit ee; int el; bit crd; bit ok;
    predict(a, wr, d, er, ee, el, crd);
    apb(a, wr, wd, d, 1'b0, rd, err, lat, ok);
    check("pready_seen", ok, 1'b1);
    if (ok) begin
      check("latency", lat, el);
      check("pslverr", err, ee);
      if (crd) check("prdata", rd, er);
    end
    if (wr && a == STAT) for (int j = 0; j < N_CH; j++) if (wd[16 + j]) m_sticky[j] = 1'b0;
  endtask

  // Every-cycle comparison of the observable state against the model
  always begin
    @(posedge clk);
    #2;
    check("div_value", div_value, model_value());
    check("gate_en", gate_en, model_gate());
    check("pready_outside_access", pready & ~(psel & penable), 1'b0);
    check("pready_two_cycles", pready & prev_ready, 1'b0);
    check("pslverr_without_pready", pslverr & ~pready, 1'b0);
    prev_ready = pready;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd; bit err; int lat; bit ok;
    logic [11:0] a;
    model_reset();
    #23 rst_n = 1'b1;

    check("reset_gate_en", gate_en, 3'b111);
    check("reset_div_value", div_value, '0);
    txn(12'hF00, 1'b0, '0, 0, rd, err, lat);
    check("reset_rd_ch0", rd, 32'h8000_0000);
    txn(STAT, 1'b0, '0, 0, rd, err, lat);
    check("reset_rd_status", rd, 32'h0000_0000);

    txn(12'hF08, 1'b1, 32'h0000_0004, 3, rd, err, lat);
    check("wr_ch1_latency", lat, 5);
    txn(12'hF08, 1'b0, '0, 0, rd, err, lat);
    check("rd_ch1", rd, 32'h0000_0004);
    check("gate_after_ch1", gate_en, 3'b101);

    txn(12'h100, 1'b0, '0, 0, rd, err, lat);
    check("unmapped_rd_err", err, 1'b1);
    check("unmapped_rd_data", rd, 32'h0);
    txn(12'hF04, 1'b1, 32'hFFFF_FFFF, 0, rd, err, lat);
    check("unmapped_wr_err", err, 1'b1);
    check("unmapped_wr_latency", lat, 1);

    txn(12'hF10, 1'b1, 32'h8000_0021, 0, rd, err, lat);
    check("wr_ch2_ack_high_latency", lat, 2);
    txn(12'hF10, 1'b0, '0, 0, rd, err, lat);
    check("rd_ch2", rd, 32'h8000_0021);

    // Reset while a ch0 update is pending
    @(negedge clk);
    paddr = 12'hF00; pwrite = 1'b1; pwdata = 32'h0000_0055; psel = 1'b1; penable = 1'b0; div_ack = '0;
    @(negedge clk); penable = 1'b1;
    @(negedge clk);
    check("req_valid_before_reset", div_valid, 3'b001);
    model_reset();
    rst_n = 1'b0;
    #1;
    check("reset_drops_valid", div_valid, 3'b000);
    check("reset_div_value_mid", div_value, '0);
    check("reset_gate_mid", gate_en, 3'b111);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    txn(12'hF00, 1'b1, 32'h0000_0012, 1, rd, err, lat);
    txn(12'hF00, 1'b0, '0, 0, rd, err, lat);
    check("rd_ch0_after_reset", rd, 32'h0000_0012);

    // Master abandons the transfer mid-handshake; the update must still land
    apb(12'hF08, 1'b1, 32'h8000_0077, 2, 1'b1, rd, err, lat, ok);
    check("abort_handshake_done", ok, 1'b1);
    txn(12'hF08, 1'b0, '0, 0, rd, err, lat);
    check("rd_ch1_after_abort", rd, 32'h8000_0077);

`ifdef APB_CLK_DIV_CTRL_TIMEOUT_EN
    txn(12'hF00, 1'b1, 32'h0000_0099, -1, rd, err, lat);
    check("timeout_err", err, 1'b1);
    check("timeout_latency", lat, TO + 1);
    txn(STAT, 1'b0, '0, 0, rd, err, lat);
    check("sticky_set", rd, 32'h0001_0000);
    txn(STAT, 1'b1, 32'h0001_0000, 0, rd, err, lat);
    txn(STAT, 1'b0, '0, 0, rd, err, lat);
    check("sticky_cleared", rd, 32'h0000_0000);
`else
    txn(STAT, 1'b1, 32'hFFFF_FFFF, 0, rd, err, lat);
    txn(STAT, 1'b0, '0, 0, rd, err, lat);
    check("status_no_sticky", rd, 32'h0000_0000);
`endif

    for (int it = 0; it < 80; it++) begin
      int op; int k;
      op = int'($urandom_range(0, 5));
      k  = int'($urandom_range(0, N_CH - 1));
      case (op)
        0: txn(12'(12'hF00 + 8 * k), 1'b0, '0, 0, rd, err, lat);
        1: txn(12'(12'hF00 + 8 * k), 1'b1, $urandom, int'($urandom_range(0, 4)), rd, err, lat);
        2: txn(STAT, 1'b0, '0, 0, rd, err, lat);
        3: txn(STAT, 1'b1, $urandom, 0, rd, err, lat);
        4: begin
          a = 12'($urandom);
          while (ch_of(a) >= 0 || a == STAT || a[1:0] != 2'b00) a = 12'($urandom);
          txn(a, 1'($urandom), $urandom, 0, rd, err, lat);
        end
        default: begin
          a = 12'(12'hF00 + 8 * k) | 12'($urandom_range(1, 3));
          txn(a, 1'($urandom), $urandom, 0, rd, err, lat);
        end
      endcase
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
